regfile_mp: RTL and testbench
=============================

Name: regfile_mp

Overview:
- Parametrised multi-port register file for the pipelined core. It replaces the fixed 16x32, 3-read/1-write file.
- Generalised in data width, depth and read-port count. Adds a second write port, optional write-to-read bypass, a read-hold (stall) input, reset of all storage, and a dedicated PC register with read offset.
- Sits between decode (read addresses) and writeback (write ports). The fetch stage drives the PC entry.

Parameters:
DATA_W, 32, width of each register and all data ports
ADDR_W, 4, address width; DEPTH = 2**ADDR_W entries
NUM_RD, 3, number of read ports (1..8)
PC_IDX, 15, index of the PC entry (must be < DEPTH)
PC_OFS, 8, constant added to the PC value when it is read through a read port
BYPASS, 1, 1 = same-cycle write data forwarded to reads of the same address; 0 = read returns the old value

Ports:
CLK  in  1  clock, all state updates on rising edge
RST  in  1  asynchronous active-high reset
RD_EN  in  1  1 = capture new read data this edge; 0 = hold RD (stall)
RA  in  NUM_RD*ADDR_W  read addresses, port k at bits [k*ADDR_W +: ADDR_W]
RD  out  NUM_RD*DATA_W  registered read data, port k at bits [k*DATA_W +: DATA_W]
WE0  in  1  write enable, port 0
WA0  in  ADDR_W  write address, port 0
WD0  in  DATA_W  write data, port 0
WE1  in  1  write enable, port 1
WA1  in  ADDR_W  write address, port 1
WD1  in  DATA_W  write data, port 1
PC_WE  in  1  load PC entry from PC_IN
PC_IN  in  DATA_W  next PC from fetch
PC_OUT  out  DATA_W  raw PC entry (no offset), direct from storage

Behaviour:
- Reset (RST=1, asynchronous): all DEPTH entries = 0, all RD lanes = 0, PC_OUT = 0. State holds while RST is high. Release is sampled at the next rising CLK.
- Read timing: reads are synchronous, 1-cycle latency. On a rising edge with RD_EN=1, lane k of RD loads the value of entry RA[k], subject to the PC and bypass rules below. With RD_EN=0, RD holds its value; writes still proceed.
- Writes: a port writes at a rising edge when its enable is high. The entry updates at that edge.
- Write collision: WE0=WE1=1 with WA0==WA1 -> port 1 wins; port 0 data is discarded.
- PC entry priority, highest first:
  - GPR write port targeting PC_IDX (port 1 over port 0)
  - PC_WE with PC_IN
  - hold
- PC read offset: a read lane with RA[k]==PC_IDX returns (stored PC + PC_OFS) mod 2**DATA_W. The stored PC is the value before the edge. PC_IN is never bypassed.
- Bypass, BYPASS=1: a lane whose RA matches an active write address in the same cycle captures the winning write data, not the stale entry.
  - If that address is PC_IDX, the lane captures write data + PC_OFS.
  - Collision priority applies to the bypass too.
- Bypass, BYPASS=0: a lane reading an address being written captures the pre-write value.
- Read lanes are independent; any number may read the same address.
- PC_OUT is combinational from the PC entry and reflects an update right after the edge that causes it.
- Wrap: PC+PC_OFS and PC_IN overflow wrap modulo 2**DATA_W; no flags.
- Out-of-range: PC_IDX >= DEPTH is illegal; flag it with an elaboration-time check.
- Reset mid-stall or mid-write: reset dominates; the write in flight is lost.

Test Plan:
- Reset: RST=1 with random RA/WE activity -> RD=0 on all lanes and PC_OUT=0. After release, reading entries 0..14 -> 0, and reading PC_IDX -> 8.
- Basic write/read: WE0=1, WA0=3, WD0=0xDEADBEEF at edge n; RA[0]=3 at edge n+1 -> RD lane0=0xDEADBEEF after edge n+1.
- Collision and bypass (BYPASS=1): WA0=WA1=5, WD0=0x11, WD1=0x22, RA[1]=5 at the same edge -> RD lane1=0x22 that edge, and entry 5 reads 0x22 later. Repeat with BYPASS=0 -> lane1 returns the old value (0).
- PC handling:
  - PC_WE=1, PC_IN=0x100 -> PC_OUT=0x100; RA[2]=15 next edge -> 0x108.
  - Same edge with WE1=1, WA1=15, WD1=0x200 -> PC_OUT=0x200 (GPR write wins over PC_IN).
- Stall: load RD lane0=0xAA, then RD_EN=0 while writing entry 1=0xBB with RA[0]=1 -> RD stays 0xAA. Set RD_EN=1 -> RD=0xBB.
- Wrap and async reset: PC_IN=0xFFFFFFFC, read PC -> 0x00000004. Assert RST between clock edges -> RD and PC_OUT go to 0 immediately, with no clock edge needed.

Source files
------------

// File: rtl/regfile_mp.sv
// Multi-port register file: NUM_RD registered read lanes, two GPR write ports,
// and a dedicated PC entry with a constant read offset and fetch-side load port.
module regfile_mp #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 4,
   parameter int NUM_RD = 3,
   parameter int PC_IDX = 15,
   parameter int PC_OFS = 8,
   parameter int BYPASS = 1
) (
   input  logic                     CLK,
   input  logic                     RST,
   input  logic                     RD_EN,
   input  logic [NUM_RD*ADDR_W-1:0] RA,
   output logic [NUM_RD*DATA_W-1:0] RD,
   input  logic                     WE0,
   input  logic [ADDR_W-1:0]        WA0,
   input  logic [DATA_W-1:0]        WD0,
   input  logic                     WE1,
   input  logic [ADDR_W-1:0]        WA1,
   input  logic [DATA_W-1:0]        WD1,
   input  logic                     PC_WE,
   input  logic [DATA_W-1:0]        PC_IN,
   output logic [DATA_W-1:0]        PC_OUT
);

   localparam int DEPTH = 2 ** ADDR_W;
   localparam logic [ADDR_W-1:0] PC_ADDR   = ADDR_W'(PC_IDX);
   localparam logic [DATA_W-1:0] PC_OFFSET = DATA_W'(PC_OFS);

   if (PC_IDX < 0 || PC_IDX >= DEPTH) begin : g_bad_pc_idx
      $error("regfile_mp: PC_IDX must lie inside the register file");
   end
   if (NUM_RD < 1 || NUM_RD > 8) begin : g_bad_num_rd
      $error("regfile_mp: NUM_RD must be between 1 and 8");
   end

   logic [DATA_W-1:0] mem [DEPTH];
   logic [DEPTH-1:0]  hit0;
   logic [DEPTH-1:0]  hit1;

   always_comb begin
      hit0 = '0;
      hit1 = '0;
      if (WE0) hit0[WA0] = 1'b1;
      if (WE1) hit1[WA1] = 1'b1;
   end

   // Per-entry priority: port 1, then port 0, then the fetch-side PC load.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      end else begin
         for (int i = 0; i < DEPTH; i++) begin
            if (hit1[i])                 mem[i] <= WD1;
            else if (hit0[i])            mem[i] <= WD0;
            else if (i == PC_IDX && PC_WE) mem[i] <= PC_IN;
         end
      end
   end

   assign PC_OUT = mem[PC_IDX];

   for (genvar k = 0; k < NUM_RD; k++) begin : g_lane
      logic [ADDR_W-1:0] ra;
      logic [DATA_W-1:0] src;
      logic [DATA_W-1:0] nxt;
      logic [DATA_W-1:0] rd_q;

      assign ra = RA[k*ADDR_W +: ADDR_W];

      // PC_IN is deliberately not forwarded; only GPR writes bypass.
      always_comb begin
         src = mem[ra];
         if (BYPASS != 0) begin
            if (WE1 && WA1 == ra)      src = WD1;
            else if (WE0 && WA0 == ra) src = WD0;
         end
         nxt = (ra == PC_ADDR) ? src + PC_OFFSET : src;
      end

      always_ff @(posedge CLK or posedge RST) begin
         if (RST)        rd_q <= '0;
         else if (RD_EN) rd_q <= nxt;
      end

      assign RD[k*DATA_W +: DATA_W] = rd_q;
   end

endmodule

// File: tb/tb_regfile_mp.sv
// Randomised scoreboard bench: one DUT with bypass, one without, both driven
// identically and compared against an array-based reference model.
module tb_regfile_mp;

   localparam int DW  = 32;
   localparam int AW  = 4;
   localparam int NR  = 3;
   localparam int PCI = 15;
   localparam int OFS = 8;

   logic          CLK = 1'b0;
   logic          RST = 1'b0;
   logic          RD_EN = 1'b0;
   logic [NR*AW-1:0] RA = '0;
   logic [NR*DW-1:0] rd_byp, rd_nobyp;
   logic          WE0 = 1'b0, WE1 = 1'b0, PC_WE = 1'b0;
   logic [AW-1:0] WA0 = '0, WA1 = '0;
   logic [DW-1:0] WD0 = '0, WD1 = '0, PC_IN = '0;
   logic [DW-1:0] pc_byp, pc_nobyp;

   typedef struct {
      logic [NR*DW-1:0] rd1;
      logic [NR*DW-1:0] rd0;
      logic [DW-1:0]    pc;
   } exp_t;

   exp_t        exp_q[$];
   logic [DW-1:0] mdl_mem [16];
   logic [DW-1:0] mdl_rd1 [NR];
   logic [DW-1:0] mdl_rd0 [NR];
   int          errors = 0;
   int          checks = 0;

   always #5 CLK = ~CLK;

   regfile_mp #(.DATA_W(DW), .ADDR_W(AW), .NUM_RD(NR), .PC_IDX(PCI), .PC_OFS(OFS), .BYPASS(1)) dut_byp (
      .CLK(CLK), .RST(RST), .RD_EN(RD_EN), .RA(RA), .RD(rd_byp),
      .WE0(WE0), .WA0(WA0), .WD0(WD0), .WE1(WE1), .WA1(WA1), .WD1(WD1),
      .PC_WE(PC_WE), .PC_IN(PC_IN), .PC_OUT(pc_byp));

   regfile_mp #(.DATA_W(DW), .ADDR_W(AW), .NUM_RD(NR), .PC_IDX(PCI), .PC_OFS(OFS), .BYPASS(0)) dut_nobyp (
      .CLK(CLK), .RST(RST), .RD_EN(RD_EN), .RA(RA), .RD(rd_nobyp),
      .WE0(WE0), .WA0(WA0), .WD0(WD0), .WE1(WE1), .WA1(WA1), .WD1(WD1),
      .PC_WE(PC_WE), .PC_IN(PC_IN), .PC_OUT(pc_nobyp));

   function automatic logic [NR*AW-1:0] packRa(input int a0, input int a1, input int a2);
      logic [NR*AW-1:0] r;
      r[0*AW +: AW] = AW'(a0);
      r[1*AW +: AW] = AW'(a1);
      r[2*AW +: AW] = AW'(a2);
      return r;
   endfunction

   task automatic checkOutput(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic clearModel();
      for (int i = 0; i < 16; i++) mdl_mem[i] = '0;
      for (int k = 0; k < NR; k++) begin
         mdl_rd1[k] = '0;
         mdl_rd0[k] = '0;
      end
   endtask

   // Drive one cycle of inputs and record what both DUTs must show after the edge.
   task automatic applyStimulus(input logic rd_en, input logic [NR*AW-1:0] ra,
                                input logic we0, input int wa0, input logic [DW-1:0] wd0,
                                input logic we1, input int wa1, input logic [DW-1:0] wd1,
                                input logic pc_we, input logic [DW-1:0] pc_in);
      exp_t e;
      int   a;
      logic [DW-1:0] old_v, byp_v;
      @(negedge CLK);
      RD_EN = rd_en; RA = ra;
      WE0 = we0; WA0 = AW'(wa0); WD0 = wd0;
      WE1 = we1; WA1 = AW'(wa1); WD1 = wd1;
      PC_WE = pc_we; PC_IN = pc_in;
      if (rd_en) begin
         for (int k = 0; k < NR; k++) begin
            a = int'(ra[k*AW +: AW]);
            old_v = mdl_mem[a];
            byp_v = old_v;
            if (we0 && wa0 == a) byp_v = wd0;
            if (we1 && wa1 == a) byp_v = wd1;
            if (a == PCI) begin
               old_v = old_v + DW'(OFS);
               byp_v = byp_v + DW'(OFS);
            end
            mdl_rd0[k] = old_v;
            mdl_rd1[k] = byp_v;
         end
      end
      if (pc_we) mdl_mem[PCI] = pc_in;
      if (we0)   mdl_mem[wa0] = wd0;
      if (we1)   mdl_mem[wa1] = wd1;
      for (int k = 0; k < NR; k++) begin
         e.rd1[k*DW +: DW] = mdl_rd1[k];
         e.rd0[k*DW +: DW] = mdl_rd0[k];
      end
      e.pc = mdl_mem[PCI];
      exp_q.push_back(e);
   endtask

   task automatic checkAllZero(input string tag);
      for (int k = 0; k < NR; k++) begin
         checkOutput($sformatf("%s_rd_byp%0d", tag, k), rd_byp[k*DW +: DW], '0);
         checkOutput($sformatf("%s_rd_nobyp%0d", tag, k), rd_nobyp[k*DW +: DW], '0);
      end
      checkOutput($sformatf("%s_pc_byp", tag), pc_byp, '0);
      checkOutput($sformatf("%s_pc_nobyp", tag), pc_nobyp, '0);
   endtask

   // Mid-cycle assertion proves the reset is truly asynchronous.
   task automatic applyReset(input bit mid_cycle);
      if (mid_cycle) @(posedge CLK);
      #3;
      RST = 1'b1;
      #1;
      checkAllZero("rst_async");
      clearModel();
      repeat (3) begin
         @(negedge CLK);
         RD_EN = 1'($urandom); RA = NR*AW'($urandom);
         WE0 = 1'b1; WA0 = AW'($urandom); WD0 = $urandom;
         WE1 = 1'($urandom); WA1 = AW'($urandom); WD1 = $urandom;
         PC_WE = 1'b1; PC_IN = $urandom;
         #1;
         checkAllZero("rst_hold");
      end
      @(negedge CLK);
      RD_EN = 1'b0; WE0 = 1'b0; WE1 = 1'b0; PC_WE = 1'b0;
      RST = 1'b0;
   endtask

   initial begin : monitor
      exp_t e;
      forever begin
         @(posedge CLK);
         #1;
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            for (int k = 0; k < NR; k++) begin
               checkOutput($sformatf("rd_byp%0d", k), rd_byp[k*DW +: DW], e.rd1[k*DW +: DW]);
               checkOutput($sformatf("rd_nobyp%0d", k), rd_nobyp[k*DW +: DW], e.rd0[k*DW +: DW]);
            end
            checkOutput("pc_out_byp", pc_byp, e.pc);
            checkOutput("pc_out_nobyp", pc_nobyp, e.pc);
         end
      end
   end

   initial begin : watchdog
      #2000000;
      $display("[TB] FAIL watchdog: simulation did not finish in time");
      $fatal(1, "[TB] timeout");
   end

   initial begin : stimulus
      int wa0, wa1;
      logic [NR*AW-1:0] ra;
      clearModel();
      applyReset(1'b0);

      for (int b = 0; b < 16; b += 3)
         applyStimulus(1, packRa(b, (b + 1) % 16, (b + 2) % 16), 0, 0, 0, 0, 0, 0, 0, 0);

      applyStimulus(0, packRa(0, 0, 0), 1, 3, 32'hDEADBEEF, 0, 0, 0, 0, 0);
      applyStimulus(1, packRa(3, 0, 0), 0, 0, 0, 0, 0, 0, 0, 0);

      applyStimulus(1, packRa(0, 5, 0), 1, 5, 32'h11, 1, 5, 32'h22, 0, 0);
      applyStimulus(1, packRa(5, 5, 5), 0, 0, 0, 0, 0, 0, 0, 0);

      applyStimulus(1, packRa(0, 0, 15), 0, 0, 0, 0, 0, 0, 1, 32'h100);
      applyStimulus(1, packRa(0, 0, 15), 0, 0, 0, 0, 0, 0, 0, 0);
      applyStimulus(1, packRa(15, 0, 0), 0, 0, 0, 1, 15, 32'h200, 1, 32'h300);
      applyStimulus(1, packRa(15, 15, 15), 0, 0, 0, 0, 0, 0, 0, 0);

      applyStimulus(0, packRa(0, 0, 0), 1, 1, 32'hAA, 0, 0, 0, 0, 0);
      applyStimulus(1, packRa(1, 0, 0), 0, 0, 0, 0, 0, 0, 0, 0);
      applyStimulus(0, packRa(1, 0, 0), 1, 1, 32'hBB, 0, 0, 0, 0, 0);
      applyStimulus(0, packRa(1, 0, 0), 0, 0, 0, 0, 0, 0, 0, 0);
      applyStimulus(1, packRa(1, 0, 0), 0, 0, 0, 0, 0, 0, 0, 0);

      applyStimulus(0, packRa(0, 0, 0), 0, 0, 0, 0, 0, 0, 1, 32'hFFFFFFFC);
      applyStimulus(1, packRa(15, 2, 15), 0, 0, 0, 0, 0, 0, 0, 0);

      for (int n = 0; n < 400; n++) begin
         wa0 = int'($urandom_range(0, 15));
         wa1 = ($urandom_range(0, 3) == 0) ? wa0 : int'($urandom_range(0, 15));
         ra  = packRa(($urandom_range(0, 2) == 0) ? wa0 : int'($urandom_range(0, 15)),
                      ($urandom_range(0, 2) == 0) ? wa1 : int'($urandom_range(0, 15)),
                      ($urandom_range(0, 3) == 0) ? PCI : int'($urandom_range(0, 15)));
         applyStimulus(($urandom_range(0, 4) != 0), ra,
                       1'($urandom), wa0, $urandom,
                       1'($urandom), wa1, $urandom,
                       ($urandom_range(0, 3) == 0),
                       ($urandom_range(0, 1) == 0) ? $urandom : (32'hFFFFFFF8 + 32'($urandom_range(0, 7))));
      end

      applyStimulus(1, packRa(15, 3, 15), 1, 3, 32'h1234, 0, 0, 0, 1, 32'h40);
      applyReset(1'b1);
      applyStimulus(1, packRa(15, 3, 5), 0, 0, 0, 0, 0, 0, 0, 0);

      for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge CLK);
      #3;
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("[TB] FAIL drain: %0d expected responses never observed, expected 0", exp_q.size());
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
